// File: rtl/clock_display_driver.sv
// Six-digit multiplexed 7-segment driver for an HH:MM:SS clock.
// Inputs are captured once per frame, split into BCD and scanned one digit at a time.
module clock_display_driver #(
    parameter int SCAN_DIV = 4,
    parameter int LZ_BLANK = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic [4:0] hours,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       dp,
    output logic       frame_start
);

    localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);
    localparam logic [6:0]  SEG_DASH   = 7'b1000000;
    localparam logic [6:0]  SEG_BLANK  = 7'b0000000;

    logic [15:0] presc_q, presc_d;
    logic [2:0]  didx_q, didx_d;
    logic [5:0]  snap_sec_q, snap_sec_d;
    logic [5:0]  snap_min_q, snap_min_d;
    logic [4:0]  snap_hr_q, snap_hr_d;
    logic [6:0]  seg_q, seg_d;
    logic [5:0]  an_q, an_d;
    logic        dp_q, dp_d;
    logic        frame_start_q, frame_start_d;

    logic        tick;
    logic        frame_end;
    logic        snap_valid;
    logic [7:0]  sec_bcd, min_bcd, hr_bcd;
    logic [3:0]  digit;

    // Threshold ladder instead of a divider: tens are found by comparison, ones by subtraction.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] ones;
        if (v >= 6'd60)      tens = 4'd6;
        else if (v >= 6'd50) tens = 4'd5;
        else if (v >= 6'd40) tens = 4'd4;
        else if (v >= 6'd30) tens = 4'd3;
        else if (v >= 6'd20) tens = 4'd2;
        else if (v >= 6'd10) tens = 4'd1;
        else                 tens = 4'd0;
        ones = v - (6'(tens) * 6'd10);
        return {tens, ones[3:0]};
    endfunction

    function automatic logic [6:0] font(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    always_comb begin
        tick      = (presc_q == PRESC_LAST);
        frame_end = tick && (didx_q == 3'd5);

        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        didx_d  = didx_q;
        if (tick) didx_d = (didx_q == 3'd5) ? 3'd0 : didx_q + 3'd1;

        // Snapshot only at the end of a frame so a frame never mixes two times.
        snap_sec_d    = frame_end ? seconds : snap_sec_q;
        snap_min_d    = frame_end ? minutes : snap_min_q;
        snap_hr_d     = frame_end ? hours   : snap_hr_q;
        frame_start_d = frame_end;

        sec_bcd    = to_bcd(snap_sec_q);
        min_bcd    = to_bcd(snap_min_q);
        hr_bcd     = to_bcd({1'b0, snap_hr_q});
        snap_valid = (snap_sec_q <= 6'd59) && (snap_min_q <= 6'd59) && (snap_hr_q <= 5'd23);

        case (didx_q)
            3'd0:    digit = sec_bcd[3:0];
            3'd1:    digit = sec_bcd[7:4];
            3'd2:    digit = min_bcd[3:0];
            3'd3:    digit = min_bcd[7:4];
            3'd4:    digit = hr_bcd[3:0];
            default: digit = hr_bcd[7:4];
        endcase

        seg_d = snap_valid ? font(digit) : SEG_DASH;
        if ((LZ_BLANK != 0) && snap_valid && (didx_q == 3'd5) && (hr_bcd[7:4] == 4'd0))
            seg_d = SEG_BLANK;
        an_d = ~(6'b000001 << didx_q);
        dp_d = snap_valid && !snap_sec_q[0] && ((didx_q == 3'd2) || (didx_q == 3'd4));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q       <= 16'd0;
            didx_q        <= 3'd0;
            snap_sec_q    <= 6'd0;
            snap_min_q    <= 6'd0;
            snap_hr_q     <= 5'd0;
            seg_q         <= 7'd0;
            an_q          <= 6'b111111;
            dp_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            didx_q        <= didx_d;
            snap_sec_q    <= snap_sec_d;
            snap_min_q    <= snap_min_d;
            snap_hr_q     <= snap_hr_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_clock_display_driver.sv
// Bench for clock_display_driver: two instances (leading-zero blanking off/on)
// compared each cycle against a frame-counting reference model.
module tb_clock_display_driver;

    localparam int SCAN_DIV = 4;
    localparam int FRAME    = 6 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] seconds = '0;
    logic [5:0] minutes = '0;
    logic [4:0] hours = '0;
    logic [6:0] seg0, seg1;
    logic [5:0] an0, an1;
    logic       dp0, dp1, fs0, fs1;

    int total = 0;
    int bad = 0;

    // Reference model state: edges since release and the displayed snapshot.
    int cyc = 0;
    int snap_s = 0, snap_m = 0, snap_h = 0;
    logic [6:0] e_seg0, e_seg1;
    logic [5:0] e_an;
    logic       e_dp, e_fs;

    logic [6:0] font_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                  7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    clock_display_driver #(.SCAN_DIV(SCAN_DIV), .LZ_BLANK(0)) dut0 (
        .clk(clk), .rst(rst), .seconds(seconds), .minutes(minutes), .hours(hours),
        .seg(seg0), .an(an0), .dp(dp0), .frame_start(fs0)
    );

    clock_display_driver #(.SCAN_DIV(SCAN_DIV), .LZ_BLANK(1)) dut1 (
        .clk(clk), .rst(rst), .seconds(seconds), .minutes(minutes), .hours(hours),
        .seg(seg1), .an(an1), .dp(dp1), .frame_start(fs1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    task automatic render(input int d, input int s, input int m, input int h);
        int  v [6];
        bit  valid;
        v[0] = s % 10; v[1] = s / 10;
        v[2] = m % 10; v[3] = m / 10;
        v[4] = h % 10; v[5] = h / 10;
        valid  = (s <= 59) && (m <= 59) && (h <= 23);
        e_seg0 = valid ? font_tab[v[d]] : 7'b1000000;
        e_seg1 = (valid && d == 5 && v[5] == 0) ? 7'b0000000 : e_seg0;
        e_an   = 6'b111111;
        e_an[d] = 1'b0;
        e_dp   = valid && (s % 2 == 0) && (d == 2 || d == 4);
    endtask

    task automatic model_edge();
        if (!rst) begin
            cyc = 0; snap_s = 0; snap_m = 0; snap_h = 0;
            e_seg0 = '0; e_seg1 = '0; e_an = 6'b111111; e_dp = 1'b0; e_fs = 1'b0;
        end else begin
            render((cyc / SCAN_DIV) % 6, snap_s, snap_m, snap_h);
            e_fs = ((cyc % FRAME) == FRAME - 1);
            if (e_fs) begin
                snap_s = int'(seconds); snap_m = int'(minutes); snap_h = int'(hours);
            end
            cyc++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("seg",  32'(seg0), 32'(e_seg0));
        check("an",   32'(an0),  32'(e_an));
        check("dp",   32'(dp0),  32'(e_dp));
        check("fs",   32'(fs0),  32'(e_fs));
        check("seg_lz", 32'(seg1), 32'(e_seg1));
        check("an_lz",  32'(an1),  32'(e_an));
        check("dp_lz",  32'(dp1),  32'(e_dp));
        check("fs_lz",  32'(fs1),  32'(e_fs));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hours = 5'(h); minutes = 6'(m); seconds = 6'(s);
    endtask

    initial begin
        rst = 1'b0;
        run(3);
        rst = 1'b1;
        step();
        check("first_an",  32'(an0),  32'(6'b111110));
        check("first_seg", 32'(seg0), 32'(7'b0111111));

        set_time(12, 34, 56);
        run(2 * FRAME + 8);
        set_time(0, 0, 57);
        run(2 * FRAME);
        set_time(0, 0, 58);
        run(2 * FRAME);

        set_time(12, 34, 56);
        run(FRAME + 10);
        set_time(23, 59, 59);
        run(2 * FRAME);

        set_time(24, 0, 0);
        run(2 * FRAME);
        set_time(1, 2, 60);
        run(2 * FRAME);
        set_time(5, 7, 9);
        run(2 * FRAME);
        set_time(10, 59, 0);
        run(2 * FRAME);

        for (int i = 0; i < 2 * FRAME && (cyc % FRAME) != 3 * SCAN_DIV; i++) step();
        rst = 1'b0;
        step();
        check("rst_an",  32'(an0),  32'(6'b111111));
        check("rst_seg", 32'(seg0), 32'(7'd0));
        rst = 1'b1;
        run(2 * FRAME);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0)
                set_time($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
            if ($urandom_range(0, 4) != 0 && $urandom_range(0, 150) == 0) begin
                rst = 1'b0;
                step();
                rst = 1'b1;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
